// File: rtl/lifo_ser_pkg.sv
// lifo_ser_pkg: state encoding and sizing constants for lifo_serializer (PAR exists only with LIFO_SER_PARITY_EN)
package lifo_ser_pkg;
  localparam int DEF_CLKS_PER_BIT = 4;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
`ifdef LIFO_SER_PARITY_EN
    PAR   = 3'd5,
`endif
    STOP  = 3'd6
  } state_t;
endpackage

// File: rtl/lifo_serializer_baud_tick.sv
// baud_tick: down-counter reloaded to one bit period, ticking when it reaches zero
module baud_tick
  import lifo_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);
  // reload on request, otherwise count down and rest at zero
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (load) cnt <= CNT_W'(CLKS_PER_BIT - 1);
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign tick = cnt == '0;
endmodule

// File: rtl/lifo_serializer.sv
// lifo_serializer: pops LIFO words and sends them as start/data/stop frames; LIFO_SER_PARITY_EN adds an even-parity bit
module lifo_serializer
  import lifo_ser_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              empty,
  input  logic [DATA_W-1:0] lifo_dout,
  output logic              re,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);
  localparam int IDX_W = DATA_W > 1 ? $clog2(DATA_W) : 1;
`ifdef LIFO_SER_PARITY_EN
  localparam state_t AFTER_DATA = PAR;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [CNT_W-1:0] cnt;
  logic tick, load, armed, tx_d, last;
  baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (.clk, .rstn, .load, .cnt, .tick);
  assign last = idx == IDX_W'(DATA_W - 1);
  // next state, bit index, shift capture and the line level of the coming cycle
  always_comb begin
    state_d = state;
    idx_d = idx;
    sh_d = state == LOAD ? lifo_dout : sh;
    load = 1'b0;
    case (state)
      IDLE: if (armed && en && !empty) state_d = POP;
      POP: state_d = LOAD;
      LOAD: begin
        state_d = START;
        load = 1'b1;
      end
      START: if (tick) begin
        state_d = DATA;
        idx_d = '0;
        load = 1'b1;
      end
      DATA: if (tick) begin
        load = 1'b1;
        if (last) state_d = AFTER_DATA;
        else idx_d = idx + IDX_W'(1);
      end
`ifdef LIFO_SER_PARITY_EN
      PAR: if (tick) begin
        state_d = STOP;
        load = 1'b1;
      end
`endif
      STOP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LIFO_SER_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[idx_d] : state_d == PAR ? ^sh_d : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? sh_d[idx_d] : 1'b1;
`endif
  end
  // state and registered outputs; armed delays the first pop to the second edge after reset
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      armed <= 1'b0;
      tx <= 1'b1;
      re <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_d;
      sh <= sh_d;
      idx <= idx_d;
      armed <= 1'b1;
      tx <= tx_d;
      re <= state_d == POP;
      busy <= state_d != IDLE;
      frame_done <= state == STOP && cnt == CNT_W'(1);
    end
endmodule

// File: tb/tb_lifo_serializer.sv
// tb_lifo_serializer: LIFO model plus frame-level reference for lifo_serializer
module tb_lifo_serializer;
  localparam int C = 4;
`ifdef LIFO_SER_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {
    logic [7:0]  w;
    logic [10:0] fr;
  } vec_t;
  logic clk = 1'b0;
  logic rstn, en, empty, re, tx, busy, frame_done;
  logic [7:0] lifo_dout;
  logic [7:0] stack[$];
  logic [7:0] popped;
  bit pend;
  int tests = 0;
  int fails = 0;
  lifo_serializer #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clk(clk), .rstn(rstn), .en(en), .empty(empty), .lifo_dout(lifo_dout),
    .re(re), .tx(tx), .busy(busy), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask
  function automatic logic [10:0] frame_of(input logic [7:0] w);
`ifdef LIFO_SER_PARITY_EN
    return {1'b1, ^w, w, 1'b0};
`else
    return {1'b0, 1'b1, w, 1'b0};
`endif
  endfunction
  task automatic push(input logic [7:0] w);
    stack.push_back(w);
    empty = 1'b0;
  endtask
  task automatic step();
    @(negedge clk);
    if (pend) begin
      lifo_dout = popped;
      pend = 1'b0;
    end
    if (re === 1'b1) begin
      chk("re_while_empty", {31'b0, empty}, 32'd0);
      if (stack.size() > 0) begin
        popped = stack.pop_back();
        lifo_dout = 8'($urandom);
        pend = 1'b1;
        empty = stack.size() == 0;
      end
    end
  endtask
  task automatic check_frame(input logic [10:0] fr, input int bound, input int exact_wait, input bit drop_en);
    int n = 0;
    do begin
      step();
      n++;
    end while (re !== 1'b1 && n < bound);
    chk("re_seen", {31'b0, re}, 32'd1);
    if (re !== 1'b1) return;
    if (exact_wait > 0) chk("idle_gap", n, exact_wait);
    chk("pop_cycle", {29'b0, tx, busy, frame_done}, 32'b110);
    step();
    chk("load_cycle", {28'b0, tx, busy, re, frame_done}, 32'b1100);
    for (int k = 0; k < NB; k++)
      for (int c = 0; c < C; c++) begin
        step();
        if (drop_en && k == 0 && c == 0) en = 1'b0;
        chk($sformatf("frame_bit%0d_clk%0d", k, c), {28'b0, tx, busy, re, frame_done},
            {28'b0, fr[k], 1'b1, 1'b0, (k == NB - 1 && c == C - 1)});
      end
  endtask
  initial begin
    vec_t tbl[5];
    logic [7:0] exp_q[$];
    int n;
`ifdef LIFO_SER_PARITY_EN
    tbl[0] = '{8'hA5, 11'b10_10100101_0};
    tbl[1] = '{8'h07, 11'b11_00000111_0};
    tbl[2] = '{8'h00, 11'b10_00000000_0};
    tbl[3] = '{8'hFF, 11'b10_11111111_0};
    tbl[4] = '{8'h3C, 11'b10_00111100_0};
`else
    tbl[0] = '{8'hA5, 11'b0_1_10100101_0};
    tbl[1] = '{8'h07, 11'b0_1_00000111_0};
    tbl[2] = '{8'h00, 11'b0_1_00000000_0};
    tbl[3] = '{8'hFF, 11'b0_1_11111111_0};
    tbl[4] = '{8'h3C, 11'b0_1_00111100_0};
`endif
    rstn = 1'b0;
    en = 1'b1;
    empty = 1'b1;
    lifo_dout = 8'h00;
    pend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_state", {28'b0, tx, busy, re, frame_done}, 32'b1000);
    end
    rstn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("idle_when_empty", {28'b0, tx, busy, re, frame_done}, 32'b1000);
    end
    en = 1'b0;
    foreach (tbl[i]) begin
      push(tbl[i].w);
      en = 1'b1;
      check_frame(tbl[i].fr, 20, 0, 1'b0);
      en = 1'b0;
      step();
      chk("idle_after_frame", {30'b0, busy, re}, 32'b00);
    end
    push(8'h11);
    push(8'h22);
    push(8'h33);
    en = 1'b1;
    check_frame(frame_of(8'h33), 20, 0, 1'b0);
    check_frame(frame_of(8'h22), 20, 2, 1'b0);
    check_frame(frame_of(8'h11), 20, 2, 1'b0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      n += int'(re === 1'b1 || busy !== 1'b0);
    end
    chk("quiet_after_drain", n, 0);
    en = 1'b0;
    push(8'h44);
    push(8'h55);
    en = 1'b1;
    check_frame(frame_of(8'h55), 20, 0, 1'b1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n += int'(re === 1'b1);
    end
    chk("no_re_while_en_low", n, 0);
    en = 1'b1;
    check_frame(frame_of(8'h44), 20, 0, 1'b0);
    en = 1'b0;
    step();
    push(8'h5A);
    push(8'hFF);
    en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (re !== 1'b1 && n < 20);
    chk("re_before_reset", {31'b0, re}, 32'd1);
    for (int i = 0; i < 19; i++) step();
    rstn = 1'b0;
    #1;
    chk("async_reset_in_data", {29'b0, tx, busy, re}, 32'b100);
    step();
    step();
    rstn = 1'b1;
    step();
    chk("no_early_pop", {31'b0, re}, 32'd0);
    check_frame(frame_of(8'h5A), 20, 0, 1'b0);
    en = 1'b0;
    step();
    push(8'hC3);
    en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (re !== 1'b1 && n < 20);
    step();
    step();
    chk("start_bit_low", {31'b0, tx}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("async_reset_in_start", {30'b0, tx, busy}, 32'b10);
    step();
    en = 1'b0;
    rstn = 1'b1;
    step();
    step();
    chk("idle_after_reset", {29'b0, tx, busy, re}, 32'b100);
    for (int r = 0; r < 6; r++) begin
      exp_q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        logic [7:0] w;
        w = 8'($urandom);
        push(w);
        exp_q.push_front(w);
      end
      en = 1'b1;
      foreach (exp_q[i]) check_frame(frame_of(exp_q[i]), 20, i == 0 ? 0 : 2, 1'b0);
      en = 1'b0;
      step();
      chk("rand_idle", {30'b0, busy, re}, 32'b00);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lifo_serializer.md
LIFO_SERIALIZER -- requirements
Module: lifo_serializer

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4; clock cycles per serial bit, legal range 2..65535.
REQ-002 Parameter DATA_W, default 8; LIFO word width and serial payload bits per frame.
REQ-003 clk  input  1  single clock; all logic is rising-edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 en  input  1  drain enable; when low, no new LIFO read is started.
REQ-006 empty  input  1  LIFO empty flag.
REQ-007 lifo_dout  input  DATA_W  LIFO read data; valid on the cycle after re is sampled high.
REQ-008 re  output  1  LIFO read strobe, one cycle per word.
REQ-009 tx  output  1  serial line, idle high.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 frame_done  output  1  one-cycle pulse on the last cycle of a stop bit.

Function
REQ-012 The FSM shall have the states IDLE, POP, LOAD, START, DATA, PAR and STOP.
REQ-013 IDLE->POP when en=1 and empty=0; re shall be high only during the single POP cycle.
REQ-014 POP->LOAD unconditionally; in LOAD the shift register shall capture lifo_dout.
REQ-015 LOAD->START; START drives tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA shall send DATA_W bits LSB first, each held for CLKS_PER_BIT cycles, using a bit index 0..DATA_W-1.
REQ-017 After the last data bit, the FSM shall go to PAR when parity is compiled in, and to STOP otherwise.
REQ-018 STOP drives tx=1 for CLKS_PER_BIT cycles; frame_done pulses on its final cycle; then STOP->IDLE.
REQ-019 Back-to-back frames: on return to IDLE with en=1 and empty=0, POP follows on the next cycle, giving exactly 3 idle-high cycles (IDLE, POP, LOAD) between stop and start.
REQ-020 en is sampled only in IDLE; deasserting en mid-frame shall not truncate the frame.
REQ-021 empty is sampled only in IDLE; the block shall never assert re while empty=1.
REQ-022 The baud counter shall be 16 bits wide, reload at CLKS_PER_BIT-1, and count down to 0.
REQ-023 tx, re, busy and frame_done shall be registered outputs.

Reset
REQ-024 On rstn=0: state=IDLE, tx=1, re=0, busy=0, frame_done=0, counters=0, shift register=0.
REQ-025 A reset asserted mid-frame shall force tx=1 immediately, without waiting for a clock edge; the partial frame is abandoned and the popped word is lost.
REQ-026 After rstn deasserts, the first POP shall occur no earlier than the second rising edge.

Configuration
REQ-027 Macro LIFO_SER_PARITY_EN: when defined, PAR sends one even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles.
REQ-028 When LIFO_SER_PARITY_EN is undefined, the PAR state and parity logic shall be absent, and a frame shall be DATA_W+2 bits long.

Structure
REQ-029 The package lifo_ser_pkg shall hold the state enum/encoding, the default CLKS_PER_BIT and the counter-width constant.
REQ-030 The sub-module baud_tick (a counter with load/tick) shall be instantiated once; all other logic lives in lifo_serializer.

Verification
REQ-031 Reset held 3 cycles, en=1, empty=1 -> tx=1, re=0 and busy=0 throughout 50 cycles.
REQ-032 Push 8'hA5, then en=1 -> one re pulse, then tx=0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total, no parity), and frame_done pulses once.
REQ-033 With LIFO_SER_PARITY_EN, push 8'hA5 -> parity bit 0 before stop; push 8'h07 -> parity bit 1; frame is 44 cycles.
REQ-034 Push 8'h11, 8'h22, 8'h33 -> frames carry 33, 22, 11 in that order with exactly 3 idle cycles between frames; re never asserts after empty=1.
REQ-035 Assert rstn=0 during DATA bit 3 of 8'hFF -> tx=1 within the same cycle and busy=0; after release, the next frame starts cleanly from the next LIFO word.
REQ-036 Drop en during START -> the current frame completes, and there is no further re until en=1.
